// File: rtl/sd_pkg.sv
// Shared definitions for the single-sector SD cache: sector geometry and FSM encodings.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int IDX_W        = 9;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_HIT        = 3'd1;
  localparam state_t ST_WB_START   = 3'd2;
  localparam state_t ST_WB_WAIT    = 3'd3;
  localparam state_t ST_FILL_START = 3'd4;
  localparam state_t ST_FILL_WAIT  = 3'd5;
  localparam state_t ST_FLUSH_ACK  = 3'd6;

endpackage

// File: rtl/sd_sector_ram.sv
// 512x8 simple dual-port sector buffer: one write port, one registered read port, no reset.
module sd_sector_ram
  import sd_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_r [SECTOR_BYTES];

  // Write port plus registered read; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/sd_sector_cache.sv
// One-sector write-back cache between a byte-wide host port and an SD sector engine.
module sd_sector_cache
  import sd_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [31:0]      host_lba,
  input  logic [IDX_W-1:0] host_off,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             host_ack,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             sd_rstart,
  output logic             sd_wstart,
  output logic [31:0]      sd_sector,
  input  logic             sd_busy,
  input  logic             sd_done,
  input  logic             sd_outen,
  input  logic [IDX_W-1:0] sd_outaddr,
  input  logic [7:0]       sd_outbyte,
  output logic [7:0]       sd_inbyte,
  output logic             busy
);

  state_t           state_r, state_s;
  logic             valid_r, dirty_r, flush_pend_r, flush_wb_r, pf_r;
  logic [31:0]      cur_lba_r, sd_sector_r;
  logic [7:0]       host_rdata_r, sd_inbyte_r;
  logic             host_ack_r, flush_done_r, sd_rstart_r, sd_wstart_r, busy_r;
  logic             hit_s, flush_go_s, wb_go_s, fill_go_s;
  logic             ram_we_s;
  logic [IDX_W-1:0] ram_waddr_s, ram_raddr_s;
  logic [7:0]       ram_wdata_s, ram_q_s;

  sd_sector_ram u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .rdata (ram_q_s)
  );

  // Next state and RAM port steering; the read port follows host_off except during write-back
  always_comb begin
    state_s     = state_r;
    ram_we_s    = 1'b0;
    ram_waddr_s = host_off;
    ram_wdata_s = host_wdata;
    ram_raddr_s = host_off;
    hit_s       = valid_r && (host_lba == cur_lba_r);
    flush_go_s  = flush_req || flush_pend_r;
    wb_go_s     = (state_r == ST_WB_START) && !sd_busy;
    fill_go_s   = (state_r == ST_FILL_START) && !sd_busy;
    case (state_r)
      ST_IDLE: begin
        if (flush_go_s) begin
          if (valid_r && dirty_r) state_s = ST_WB_START;
          else                    state_s = ST_FLUSH_ACK;
        end else if (host_req && !host_ack_r) begin
          if (hit_s)                       state_s = ST_HIT;
          else if (valid_r && dirty_r)     state_s = ST_WB_START;
          else                             state_s = ST_FILL_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIT: begin
        ram_we_s = host_we;
        state_s  = ST_IDLE;
      end
      ST_WB_START: begin
        if (!sd_busy) state_s = ST_WB_WAIT;
        else          state_s = ST_WB_START;
      end
      ST_WB_WAIT: begin
        // SD engine asks for the byte after the one it just shifted out
        ram_raddr_s = sd_outaddr + 9'd1;
        if (sd_done) state_s = flush_wb_r ? ST_FLUSH_ACK : ST_FILL_START;
        else         state_s = ST_WB_WAIT;
      end
      ST_FILL_START: begin
        if (!sd_busy) state_s = ST_FILL_WAIT;
        else          state_s = ST_FILL_START;
      end
      ST_FILL_WAIT: begin
        ram_we_s    = sd_outen;
        ram_waddr_s = sd_outaddr;
        ram_wdata_s = sd_outbyte;
        if (sd_done) state_s = ST_HIT;
        else         state_s = ST_FILL_WAIT;
      end
      ST_FLUSH_ACK: state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // State, tags and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      valid_r      <= 1'b0;
      dirty_r      <= 1'b0;
      cur_lba_r    <= 32'd0;
      flush_pend_r <= 1'b0;
      flush_wb_r   <= 1'b0;
      pf_r         <= 1'b0;
      host_rdata_r <= 8'd0;
      host_ack_r   <= 1'b0;
      flush_done_r <= 1'b0;
      sd_rstart_r  <= 1'b0;
      sd_wstart_r  <= 1'b0;
      sd_sector_r  <= 32'd0;
      sd_inbyte_r  <= 8'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != ST_IDLE);
      host_ack_r   <= (state_r == ST_HIT);
      host_rdata_r <= (state_r == ST_HIT) ? ram_q_s : 8'd0;
      flush_done_r <= (state_r == ST_FLUSH_ACK);
      sd_wstart_r  <= wb_go_s;
      sd_rstart_r  <= fill_go_s;
      pf_r         <= (state_r == ST_WB_WAIT) && sd_outen;
      if (pf_r) sd_inbyte_r <= ram_q_s;
      if (wb_go_s)        sd_sector_r <= cur_lba_r;
      else if (fill_go_s) sd_sector_r <= host_lba;

      // A flush seen while busy waits for IDLE; IDLE always consumes it
      if (state_r == ST_IDLE)  flush_pend_r <= 1'b0;
      else if (flush_req)      flush_pend_r <= 1'b1;

      if (state_r == ST_IDLE && flush_go_s)    flush_wb_r <= 1'b1;
      else if (state_r == ST_IDLE && host_req) flush_wb_r <= 1'b0;

      if ((state_r == ST_HIT) && host_we) dirty_r <= 1'b1;
      if ((state_r == ST_WB_WAIT) && sd_done) dirty_r <= 1'b0;
      if (fill_go_s) valid_r <= 1'b0;
      if ((state_r == ST_FILL_WAIT) && sd_done) begin
        valid_r   <= 1'b1;
        dirty_r   <= 1'b0;
        cur_lba_r <= host_lba;
      end
    end
  end

  assign host_rdata = host_rdata_r;
  assign host_ack   = host_ack_r;
  assign flush_done = flush_done_r;
  assign sd_rstart  = sd_rstart_r;
  assign sd_wstart  = sd_wstart_r;
  assign sd_sector  = sd_sector_r;
  assign sd_inbyte  = sd_inbyte_r;
  assign busy       = busy_r;

endmodule
